// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with binary pointers that wrap modulo 2*DEPTH.
// It provides an occupancy count, almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, a synchronous flush and a selectable
// first-word-fall-through read port.
// All status flags are registered. Each is decoded from the next-state count,
// so it matches the registered count on every cycle.

module sync_fifo_thr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] ZERO_C  = (ADDR_WIDTH+1)'(0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH:0]   wptr_r, rptr_r, count_r;
  logic [ADDR_WIDTH:0]   wptr_nxt_s, rptr_nxt_s, count_nxt_s;
  logic                  full_r, empty_r, af_r, ae_r;
  logic                  ovf_r, unf_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  rd_valid_r;
  logic                  wr_acc_s, rd_acc_s;
  logic [DATA_WIDTH-1:0] head_s;

  // Acceptance is decided from registered flags only; flush suppresses both ports.
  always_comb begin
    wr_acc_s    = wr_req && !full_r && !flush;
    rd_acc_s    = rd_req && !empty_r && !flush;
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    count_nxt_s = count_r;
    if (flush) begin
      wptr_nxt_s  = ZERO_C;
      rptr_nxt_s  = ZERO_C;
      count_nxt_s = ZERO_C;
    end else begin
      if (wr_acc_s) begin
        wptr_nxt_s = wptr_r + ONE_C;
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (rd_acc_s) begin
        rptr_nxt_s = rptr_r + ONE_C;
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer, count and status-flag registers; flags are decoded from the next count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r  <= ZERO_C;
      rptr_r  <= ZERO_C;
      count_r <= ZERO_C;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= 1'b0;
      ae_r    <= 1'b1;
    end else begin
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == ZERO_C);
      af_r    <= (count_nxt_s >= AF_C);
      ae_r    <= (count_nxt_s <= AE_C);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  assign head_s = mem_r[rptr_r[ADDR_WIDTH-1:0]];

  // Sticky error flags: a new error in the same cycle beats clr_err, and flush leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (flush) begin
      ovf_r <= ovf_r;
      unf_r <= unf_r;
    end else begin
      if (wr_req && full_r) begin
        ovf_r <= 1'b1;
      end else if (clr_err) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (rd_req && empty_r) begin
        unf_r <= 1'b1;
      end else if (clr_err) begin
        unf_r <= 1'b0;
      end else begin
        unf_r <= unf_r;
      end
    end
  end

  // Read data register.
  // Registered mode: it captures the head word on an accepted read.
  // FWFT mode: it tracks the shown word so data_out can hold that word once the FIFO empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r     <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
      if (FWFT != 0) begin
        if (!empty_r) begin
          dout_r <= head_s;
        end else begin
          dout_r <= dout_r;
        end
      end else begin
        if (rd_acc_s) begin
          dout_r <= head_s;
        end else begin
          dout_r <= dout_r;
        end
      end
    end
  end

  assign data_out     = ((FWFT != 0) && !empty_r) ? head_s : dout_r;
  assign rd_valid     = (FWFT != 0) ? !empty_r : rd_valid_r;
  assign fifo_full    = full_r;
  assign fifo_empty   = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr. The settings are DEPTH=4, AF_THRESH=3 and AE_THRESH=1.
// One instance uses the registered read port and one uses first-word-fall-through.
// Expected flags are packed as {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}.

module tb_sync_fifo_thr;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, wr_req, rd_req, clr_err;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid, fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  logic       f_flush, f_wr, f_rd, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_thr #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

  sync_fifo_thr #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(f_flush), .wr_req(f_wr), .data_in(f_din), .rd_req(f_rd),
    .data_out(f_dout), .rd_valid(f_rv), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr));

  typedef struct {
    logic       wr, rd, fl, clr;
    logic [7:0] din;
    logic [2:0] cnt;
    logic [6:0] flags;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic rd, input logic fl, input logic clr,
                     input logic [7:0] din, input logic [2:0] cnt, input logic [6:0] flags,
                     input logic [7:0] dout);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
    v.cnt = cnt; v.flags = flags; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [2:0] cnt,
                            input logic [6:0] flags, input logic [7:0] dout);
    logic [6:0] act;
    act = {fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow, rd_valid};
    n_vec++;
    if (count !== cnt) begin
      n_err++;
      $display("FAIL %s[%0d] count: got %0d want %0d", tag, idx, count, cnt);
    end
    if (act !== flags) begin
      n_err++;
      $display("FAIL %s[%0d] flags F/E/AF/AE/OV/UN/RV: got %b want %b", tag, idx, act, flags);
    end
    if (data_out !== dout) begin
      n_err++;
      $display("FAIL %s[%0d] data_out: got %h want %h", tag, idx, data_out, dout);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr,
                       input logic [7:0] din);
    @(negedge clk);
    wr_req = wr; rd_req = rd; flush = fl; clr_err = clr; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] last;
    rst = 1'b0; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; data_in = 8'h00;
    f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;

    // Fill to full, overflow, then drain in order
    add(1'b1,1'b0,1'b0,1'b0, 8'h11, 3'd1, 7'b0001000, 8'h00);
    add(1'b1,1'b0,1'b0,1'b0, 8'h22, 3'd2, 7'b0000000, 8'h00);
    add(1'b1,1'b0,1'b0,1'b0, 8'h33, 3'd3, 7'b0010000, 8'h00);
    add(1'b1,1'b0,1'b0,1'b0, 8'h44, 3'd4, 7'b1010000, 8'h00);
    add(1'b1,1'b0,1'b0,1'b0, 8'h55, 3'd4, 7'b1010100, 8'h00);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd3, 7'b0010101, 8'h11);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd2, 7'b0000101, 8'h22);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd1, 7'b0001101, 8'h33);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd0, 7'b0101101, 8'h44);
    // Refill, then write+read while full: read wins, 66 dropped
    add(1'b1,1'b0,1'b0,1'b0, 8'h01, 3'd1, 7'b0001100, 8'h44);
    add(1'b1,1'b0,1'b0,1'b0, 8'h02, 3'd2, 7'b0000100, 8'h44);
    add(1'b1,1'b0,1'b0,1'b0, 8'h03, 3'd3, 7'b0010100, 8'h44);
    add(1'b1,1'b0,1'b0,1'b0, 8'h04, 3'd4, 7'b1010100, 8'h44);
    add(1'b1,1'b1,1'b0,1'b0, 8'h66, 3'd3, 7'b0010101, 8'h01);
    add(1'b0,1'b0,1'b0,1'b1, 8'h00, 3'd3, 7'b0010000, 8'h01);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd2, 7'b0000001, 8'h02);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd1, 7'b0001001, 8'h03);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd0, 7'b0101001, 8'h04);
    // Empty: underflow, then write+read while empty: write wins
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd0, 7'b0101010, 8'h04);
    add(1'b1,1'b1,1'b0,1'b0, 8'h77, 3'd1, 7'b0001010, 8'h04);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd0, 7'b0101011, 8'h77);
    add(1'b0,1'b1,1'b0,1'b1, 8'h00, 3'd0, 7'b0101010, 8'h77);
    // Three entries, then flush with wr/rd asserted: both ignored, error and data kept
    add(1'b1,1'b0,1'b0,1'b0, 8'h0A, 3'd1, 7'b0001010, 8'h77);
    add(1'b1,1'b0,1'b0,1'b0, 8'h0B, 3'd2, 7'b0000010, 8'h77);
    add(1'b1,1'b0,1'b0,1'b0, 8'h0C, 3'd3, 7'b0010010, 8'h77);
    add(1'b1,1'b1,1'b1,1'b0, 8'h99, 3'd0, 7'b0101010, 8'h77);
    add(1'b1,1'b0,1'b0,1'b0, 8'h5A, 3'd1, 7'b0001010, 8'h77);
    add(1'b0,1'b1,1'b0,1'b0, 8'h00, 3'd0, 7'b0101011, 8'h5A);
    add(1'b0,1'b0,1'b0,1'b1, 8'h00, 3'd0, 7'b0101000, 8'h5A);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 3'd0, 7'b0101000, 8'h00);
    chk("fwft_reset_empty", {7'd0, f_empty}, 8'h01);
    chk("fwft_reset_dout", f_dout, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].fl, vecs[i].clr, vecs[i].din);
      check_outs("table", i, vecs[i].cnt, vecs[i].flags, vecs[i].dout);
    end

    // Wrap: 12 write/read pairs through the depth-4 array
    last = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      check_outs("wrap_wr", i, 3'd1, 7'b0001000, last);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      last = 8'(i);
      check_outs("wrap_rd", i, 3'd0, 7'b0101001, last);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // First-word-fall-through instance
    @(negedge clk); f_wr = 1'b1; f_din = 8'hA5;
    @(posedge clk); #1;
    chk("fwft_wr_empty", {7'd0, f_empty}, 8'h00);
    chk("fwft_wr_dout", f_dout, 8'hA5);
    chk("fwft_wr_rv", {7'd0, f_rv}, 8'h01);
    @(negedge clk); f_wr = 1'b0;
    @(posedge clk); #1;
    chk("fwft_idle_dout", f_dout, 8'hA5);
    @(negedge clk); f_wr = 1'b1; f_din = 8'h3C;
    @(posedge clk); #1;
    chk("fwft_wr2_dout", f_dout, 8'hA5);
    chk("fwft_wr2_cnt", {5'd0, f_count}, 8'h02);
    @(negedge clk); f_wr = 1'b0; f_rd = 1'b1;
    @(posedge clk); #1;
    chk("fwft_pop1_dout", f_dout, 8'h3C);
    chk("fwft_pop1_cnt", {5'd0, f_count}, 8'h01);
    @(posedge clk); #1;
    chk("fwft_pop2_empty", {7'd0, f_empty}, 8'h01);
    chk("fwft_pop2_rv", {7'd0, f_rv}, 8'h00);
    chk("fwft_pop2_dout", f_dout, 8'h3C);
    @(negedge clk); f_rd = 1'b0;

    // Mid-burst asynchronous reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hE1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hE2);
    check_outs("pre_rst", 0, 3'd2, 7'b0000000, 8'h0B);
    #2 rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 3'd0, 7'b0101000, 8'h00);
    chk("fwft_async_rst_dout", f_dout, 8'h00);
    @(negedge clk); wr_req = 1'b0; rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_outs("post_rst_rd", 0, 3'd0, 7'b0101010, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
